// File: rtl/hamming_pkg.sv
// Shared widths and sequencer state encoding for the Hamming(12,8) codec scheduler.
package hamming_pkg;
   localparam int DATA_W = 8;
   localparam int CW_W   = 12;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} seq_state_t;
endpackage

// File: rtl/hamming_codec_sched_if.sv
// Requester, codec and result handshakes of the codec scheduler, grouped in one bundle.
interface hamming_codec_sched_if
   import hamming_pkg::*;
#(parameter int CNT_W = 16);
   logic              ch0_valid, ch0_ready;
   logic [DATA_W-1:0] ch0_data;
   logic              ch1_valid, ch1_ready;
   logic [DATA_W-1:0] ch1_data;
   logic              enc_wren;
   logic [DATA_W-1:0] enc_data;
   logic [CW_W-1:0]   enc_hc;
   logic              eo_valid, eo_ready, eo_src;
   logic [CW_W-1:0]   eo_hc;
   logic              cw_valid, cw_ready;
   logic [CW_W-1:0]   cw_data;
   logic              dec_rden;
   logic [CW_W-1:0]   dec_hc;
   logic [DATA_W-1:0] dec_q;
   logic              do_valid, do_ready;
   logic [DATA_W-1:0] do_data;
   logic [CNT_W-1:0]  enc_cnt, dec_cnt;

   modport slave (
      input  ch0_valid, ch0_data, ch1_valid, ch1_data, enc_hc, eo_ready,
             cw_valid, cw_data, dec_q, do_ready,
      output ch0_ready, ch1_ready, enc_wren, enc_data, eo_valid, eo_hc, eo_src,
             cw_ready, dec_rden, dec_hc, do_valid, do_data, enc_cnt, dec_cnt
   );

   modport master (
      output ch0_valid, ch0_data, ch1_valid, ch1_data, enc_hc, eo_ready,
             cw_valid, cw_data, dec_q, do_ready,
      input  ch0_ready, ch1_ready, enc_wren, enc_data, eo_valid, eo_hc, eo_src,
             cw_ready, dec_rden, dec_hc, do_valid, do_data, enc_cnt, dec_cnt
   );
endinterface

// File: rtl/codec_seq.sv
// One codec transaction sequencer: accept, strobe, wait LAT cycles, capture, hold until taken.
module codec_seq
   import hamming_pkg::*;
#(
   parameter int LAT   = 1,
   parameter int IN_W  = 8,
   parameter int RES_W = 12,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             acc,
   input  logic [IN_W-1:0]  in_data,
   input  logic [RES_W-1:0] res,
   input  logic             out_ready,
   output logic             idle,
   output logic             strobe,
   output logic [IN_W-1:0]  held,
   output logic             out_valid,
   output logic [RES_W-1:0] out_data,
   output logic [CNT_W-1:0] cnt
);
   localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;

   seq_state_t      state;
   logic [WC_W-1:0] wcnt;

   assign idle = (state == IDLE);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= IDLE;
         wcnt      <= '0;
         strobe    <= 1'b0;
         held      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         cnt       <= '0;
      end else begin
         strobe <= 1'b0;
         case (state)
            IDLE: if (acc) begin
               held   <= in_data;
               strobe <= 1'b1;
               state  <= ISSUE;
            end
            ISSUE: begin
               wcnt  <= WC_W'(LAT - 1);
               state <= WAIT;
            end
            // the codec result is valid during the last WAIT cycle
            WAIT: if (wcnt == '0) begin
               out_data  <= res;
               out_valid <= 1'b1;
               state     <= HOLD;
            end else begin
               wcnt <= wcnt - 1'b1;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               cnt       <= cnt + 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/hamming_codec_sched.sv
// Round-robin arbitration of two byte requesters onto the encoder, plus an independent decode sequencer.
module hamming_codec_sched
   import hamming_pkg::*;
#(
   parameter int ENC_LAT = 1,
   parameter int DEC_LAT = 1,
   parameter int CNT_W   = 16
) (
   input logic                  clk,
   input logic                  arst,
   hamming_codec_sched_if.slave bus
);
   logic            rr_last, g1, any_v, enc_idle, dec_idle;
   logic [DATA_W:0] enc_held;

   // rr_last==1 means ch1 was served last, so ch0 wins the next tie
   assign any_v = bus.ch0_valid | bus.ch1_valid;
   assign g1    = bus.ch1_valid & (~bus.ch0_valid | ~rr_last);

   assign bus.ch0_ready = enc_idle & any_v & ~g1 & ~arst;
   assign bus.ch1_ready = enc_idle & g1 & ~arst;
   assign bus.cw_ready  = dec_idle & ~arst;

   always_ff @(posedge clk or posedge arst) begin
      if (arst)                 rr_last <= 1'b1;
      else if (enc_idle & any_v) rr_last <= g1;
   end

   codec_seq #(.LAT(ENC_LAT), .IN_W(DATA_W+1), .RES_W(CW_W), .CNT_W(CNT_W)) u_enc (
      .clk       (clk),
      .arst      (arst),
      .acc       (enc_idle & any_v),
      .in_data   ({g1, g1 ? bus.ch1_data : bus.ch0_data}),
      .res       (bus.enc_hc),
      .out_ready (bus.eo_ready),
      .idle      (enc_idle),
      .strobe    (bus.enc_wren),
      .held      (enc_held),
      .out_valid (bus.eo_valid),
      .out_data  (bus.eo_hc),
      .cnt       (bus.enc_cnt)
   );

   assign bus.enc_data = enc_held[DATA_W-1:0];
   assign bus.eo_src   = enc_held[DATA_W];

   codec_seq #(.LAT(DEC_LAT), .IN_W(CW_W), .RES_W(DATA_W), .CNT_W(CNT_W)) u_dec (
      .clk       (clk),
      .arst      (arst),
      .acc       (dec_idle & bus.cw_valid),
      .in_data   (bus.cw_data),
      .res       (bus.dec_q),
      .out_ready (bus.do_ready),
      .idle      (dec_idle),
      .strobe    (bus.dec_rden),
      .held      (bus.dec_hc),
      .out_valid (bus.do_valid),
      .out_data  (bus.do_data),
      .cnt       (bus.dec_cnt)
   );
endmodule
